output_layer: RTL and testbench

Fully connected output layer of the digit classifier. It computes the 10 class scores `score[i] = bias[i] + sum_j w[i][j]*h[j]` from the hidden-layer activations using one sequential MAC and an external weight ROM. It sits directly upstream of the argmax stage: `output_nums` drives that stage's `input_nums`, and `done` drives its `start`.

---
 rtl/output_layer.sv | 149 ++++++++++++++
 tb/tb_output_layer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_layer.sv
// rtl/output_layer.sv - fully connected 10-class output layer with one sequential MAC and external weight ROM
module output_layer #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int N_IN  = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [N_IN*WIDTH-1:0]                hidden_nums,
    output logic [$clog2(10*(N_IN+1))-1:0]       w_addr,
    input  logic [WIDTH-1:0]                     w_data,
    output logic [10*WIDTH-1:0]                  output_nums,
    output logic                                 done,
    output logic                                 busy
);

    localparam int AW    = $clog2(10*(N_IN+1));
    localparam int JW    = $clog2(N_IN+1);
    localparam int ACC_W = 2*WIDTH + JW;
    localparam int SW    = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [3:0]               i;
    logic [JW-1:0]            j;
    logic [3:0]               i_d;
    logic [JW-1:0]            j_d;
    logic                     acc_valid;
    logic [N_IN*WIDTH-1:0]    h_reg;
    logic signed [ACC_W-1:0]  acc;
    logic [WIDTH-1:0]         score [0:9];

    // Extra zero entry lets j_d index the array directly even on the bias word.
    logic signed [WIDTH-1:0]  h_arr [0:N_IN];

    logic signed [2*WIDTH-1:0] wx;
    logic signed [2*WIDTH-1:0] hx;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [SW-1:0]      bias_sh;
    logic signed [SW-1:0]      sum;
    logic signed [SW-1:0]      r;
    logic [WIDTH-1:0]          sat;

    genvar g;
    generate
        for (g = 0; g < N_IN; g++) begin : g_h
            assign h_arr[g] = h_reg[g*WIDTH +: WIDTH];
        end
        for (g = 0; g < 10; g++) begin : g_out
            assign output_nums[g*WIDTH +: WIDTH] = score[g];
        end
    endgenerate
    assign h_arr[N_IN] = '0;

    // MAC datapath and bias/scale/saturate of a finished neuron.
    always_comb begin
        wx       = {{WIDTH{w_data[WIDTH-1]}}, w_data};
        hx       = {{WIDTH{h_arr[j_d][WIDTH-1]}}, h_arr[j_d]};
        prod     = wx * hx;
        prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        bias_sh  = {{(SW-WIDTH){w_data[WIDTH-1]}}, w_data};
        bias_sh  = bias_sh <<< FRAC;
        sum      = {acc[ACC_W-1], acc} + bias_sh;
        r        = sum >>> FRAC;
        if ((&r[SW-1:WIDTH-1]) || !(|r[SW-1:WIDTH-1])) begin
            sat = r[WIDTH-1:0];
        end else if (r[SW-1]) begin
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Control FSM, address stage and the one-cycle-delayed accumulate stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            i_d       <= '0;
            j_d       <= '0;
            acc_valid <= 1'b0;
            h_reg     <= '0;
            acc       <= '0;
            w_addr    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < 10; k++) begin
                score[k] <= '0;
            end
        end else begin
            done      <= 1'b0;
            acc_valid <= 1'b0;

            if (acc_valid) begin
                if (j_d == JW'(N_IN)) begin
                    score[i_d] <= sat;
                    acc        <= '0;
                end else begin
                    acc <= acc + prod_ext;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        h_reg  <= hidden_nums;
                        acc    <= '0;
                        i      <= '0;
                        j      <= '0;
                        w_addr <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_valid <= 1'b1;
                    i_d       <= i;
                    j_d       <= j;
                    if (j == JW'(N_IN)) begin
                        if (i == 4'd9) begin
                            state <= DRAIN;
                        end else begin
                            i      <= i + 4'd1;
                            j      <= '0;
                            w_addr <= w_addr + AW'(1);
                        end
                    end else begin
                        j      <= j + JW'(1);
                        w_addr <= w_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer.sv
// tb/tb_output_layer.sv - scoreboard bench for output_layer with a 1-cycle behavioural weight ROM
module tb_output_layer;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int N_IN  = 4;
    localparam int T     = 10*(N_IN+1);
    localparam int AW    = $clog2(T);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [N_IN*WIDTH-1:0]  hidden_nums;
    logic [AW-1:0]          w_addr;
    logic [WIDTH-1:0]       w_data;
    logic [10*WIDTH-1:0]    output_nums;
    logic                   done;
    logic                   busy;

    output_layer #(.WIDTH(WIDTH), .FRAC(FRAC), .N_IN(N_IN)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hidden_nums (hidden_nums),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .output_nums (output_nums),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rom [0:T-1];
    always @(posedge clk) w_data <= rom[w_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] alog [0:4095];
    always @(negedge clk) alog[cyc % 4096] = w_addr;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int                  e0;
        logic [10*WIDTH-1:0] scores;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    localparam logic [10*WIDTH-1:0] POS1 = {32'h000D0000, 32'h000C0000, 32'h000B0000, 32'h000A0000, 32'h00090000,
                                           32'h00080000, 32'h00070000, 32'h00060000, 32'h00050000, 32'h00040000};
    localparam logic [10*WIDTH-1:0] POS2 = {32'h00110000, 32'h00100000, 32'h000F0000, 32'h000E0000, 32'h000D0000,
                                           32'h000C0000, 32'h000B0000, 32'h000A0000, 32'h00090000, 32'h00080000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [10*WIDTH-1:0] fill(input logic [WIDTH-1:0] v);
        logic [10*WIDTH-1:0] o;
        for (int k = 0; k < 10; k++) o[k*WIDTH +: WIDTH] = v;
        return o;
    endfunction

    task automatic load_rom(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] bbase, input logic [WIDTH-1:0] bstep);
        for (int n = 0; n < 10; n++)
            for (int m = 0; m <= N_IN; m++)
                rom[n*(N_IN+1)+m] = (m < N_IN) ? w : bbase + WIDTH'(n) * bstep;
    endtask

    task automatic set_h(input logic [WIDTH-1:0] v);
        for (int m = 0; m < N_IN; m++) hidden_nums[m*WIDTH +: WIDTH] = v;
    endtask

    task automatic issue(input bit push, input logic [10*WIDTH-1:0] exp);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        e.e0 = cyc;
        e.scores = exp;
        if (push) sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL wait_done: done never seen within 200 cycles, expected a done pulse");
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected inference.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                int bad;
                mon_e = sbq.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_e.e0 + T + 2));
                check("busy_at_done", 64'(busy), 64'd1);
                for (int k = 0; k < 10; k++)
                    check($sformatf("score%0d", k), 64'(output_nums[k*WIDTH +: WIDTH]),
                          64'(mon_e.scores[k*WIDTH +: WIDTH]));
                bad = 0;
                for (int k = 0; k < T; k++)
                    if (alog[(mon_e.e0 + k + 1) % 4096] !== AW'(k)) bad++;
                check("addr_seq_errors", 64'(bad), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1;
        reset = 1'b0;
        start = 1'b0;
        hidden_nums = '0;
        load_rom('0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_w_addr", 64'(w_addr), 64'd0);
        check("rst_output", 64'(|output_nums), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        load_rom(32'h00010000, 32'h0, 32'h00010000);
        set_h(32'h00010000);
        issue(1'b1, POS1);
        wait_done();
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);

        load_rom(32'hFFFE8000, 32'h0, 32'h0);
        set_h(32'h00020000);
        issue(1'b1, fill(32'hFFF40000));
        wait_done();
        @(negedge clk);

        load_rom(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
        set_h(32'h7FFFFFFF);
        issue(1'b1, fill(32'h7FFFFFFF));
        wait_done();
        @(negedge clk);

        load_rom(32'h80000000, 32'h7FFFFFFF, 32'h0);
        issue(1'b1, fill(32'h80000000));
        wait_done();
        @(negedge clk);

        load_rom(32'h00010000, 32'h0, 32'h00010000);
        set_h(32'h00010000);
        issue(1'b1, POS1);
        repeat (8) @(negedge clk);
        set_h(32'h00020000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        set_h(32'h00010000);
        issue(1'b1, POS1);
        wait_done();
        d1 = cyc;
        @(negedge clk);
        check("hold_output", 64'(output_nums == POS1), 64'd1);
        begin
            exp_t e;
            set_h(32'h00020000);
            start = 1'b1;
            e.e0 = cyc;
            e.scores = POS2;
            sbq.push_back(e);
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        check("b2b_gap", 64'(cyc - d1), 64'(T + 3));
        @(negedge clk);

        set_h(32'h00010000);
        issue(1'b0, '0);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_w_addr", 64'(w_addr), 64'd0);
        check("abort_output", 64'(|output_nums), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (70) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_w_addr", 64'(w_addr), 64'd0);
        issue(1'b1, POS1);
        wait_done();
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
